// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style slave terminating AW/W/B and AR/R onto a
// byte-strobed register memory. Each direction has one outstanding burst.
// FIXED/INCR/WRAP bursts are supported; the reserved burst code and
// oversize beats complete normally but answer SLVERR.
// Ports: aclk/aresetn (sync, active-low); s_aw*/s_w*/s_b* write channels;
// s_ar*/s_r* read channels.

// One byte lane of storage: synchronous write, combinational read.
module axi_sram_lane #(
  parameter int DEPTH = 1024,
  parameter int IDXW  = 10
) (
  input  logic            aclk,
  input  logic            we,
  input  logic [IDXW-1:0] widx,
  input  logic [7:0]      wbyte,
  input  logic [IDXW-1:0] ridx,
  output logic [7:0]      rbyte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge aclk)
    if (we) mem[widx] <= wbyte;

  assign rbyte = mem[ridx];
endmodule

module axi_sram_slave #(
  parameter int AXI_AXID_WIDTH    = 10,
  parameter int AXI_AXADDR_WIDTH  = 32,
  parameter int AXI_AXLEN_WIDTH   = 8,
  parameter int AXI_AXSIZE_WIDTH  = 3,
  parameter int AXI_AXBURST_WIDTH = 2,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_RESP_WIDTH    = 2,
  parameter int MEM_DEPTH         = 1024
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXI_AXID_WIDTH-1:0]    s_awid,
  input  logic [AXI_AXADDR_WIDTH-1:0]  s_awaddr,
  input  logic [AXI_AXLEN_WIDTH-1:0]   s_awlen,
  input  logic [AXI_AXSIZE_WIDTH-1:0]  s_awsize,
  input  logic [AXI_AXBURST_WIDTH-1:0] s_awburst,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [AXI_AXID_WIDTH-1:0]    s_wid,
  input  logic [AXI_DATA_WIDTH-1:0]    s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_wstrb,
  input  logic                         s_wlast,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [AXI_AXID_WIDTH-1:0]    s_bid,
  output logic [AXI_RESP_WIDTH-1:0]    s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [AXI_AXID_WIDTH-1:0]    s_arid,
  input  logic [AXI_AXADDR_WIDTH-1:0]  s_araddr,
  input  logic [AXI_AXLEN_WIDTH-1:0]   s_arlen,
  input  logic [AXI_AXSIZE_WIDTH-1:0]  s_arsize,
  input  logic [AXI_AXBURST_WIDTH-1:0] s_arburst,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [AXI_AXID_WIDTH-1:0]    s_rid,
  output logic [AXI_DATA_WIDTH-1:0]    s_rdata,
  output logic [AXI_RESP_WIDTH-1:0]    s_rresp,
  output logic                         s_rlast,
  output logic                         s_rvalid,
  input  logic                         s_rready
);
  localparam int AW   = AXI_AXADDR_WIDTH;
  localparam int LW   = AXI_AXLEN_WIDTH;
  localparam int SW   = AXI_AXSIZE_WIDTH;
  localparam int BW   = AXI_AXBURST_WIDTH;
  localparam int IW   = AXI_AXID_WIDTH;
  localparam int NB   = AXI_DATA_WIDTH / 8;
  localparam int OFF  = $clog2(NB);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam logic [AXI_RESP_WIDTH-1:0] OKAY   = AXI_RESP_WIDTH'(0);
  localparam logic [AXI_RESP_WIDTH-1:0] SLVERR = AXI_RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
      input logic [LW-1:0] len, input logic [SW-1:0] size, input logic [BW-1:0] burst);
    logic [AW-1:0] b, aligned, bound;
    b       = AW'(1) << size;
    aligned = a & ~(b - AW'(1));
    bound   = (AW'(len) + AW'(1)) * b;
    if (burst == BW'(0))      next_addr = a;
    else if (burst == BW'(2)) next_addr = (a & ~(bound - AW'(1))) |
                                          ((aligned + b) & (bound - AW'(1)));
    else                      next_addr = aligned + b;  // INCR and reserved
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] a);
    word_idx = a[OFF +: IDXW];
  endfunction

  function automatic logic bad_req(input logic [SW-1:0] size, input logic [BW-1:0] burst);
    bad_req = (burst == {BW{1'b1}}) || (int'(size) > OFF);
  endfunction

  // ---------------- write path ----------------
  w_state_t      w_state, w_next;
  logic [IW-1:0] w_id;
  logic [AW-1:0] w_addr;
  logic [LW-1:0] w_len, w_cnt;
  logic [SW-1:0] w_size;
  logic [BW-1:0] w_burst;
  logic          w_err;

  assign s_awready = (w_state == W_IDLE);
  assign s_wready  = (w_state == W_DATA);

  logic w_fire, w_last_beat, beat_err;
  assign w_fire      = (w_state == W_DATA) && s_wvalid;
  assign w_last_beat = (w_cnt == w_len);
  assign beat_err    = (s_wlast != w_last_beat) || (s_wid != w_id);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_awvalid)              w_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat)  w_next = W_RESP;
      W_RESP:  if (s_bready)               w_next = W_IDLE;
      default:                             w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
      w_size <= '0; w_burst <= '0; w_err <= 1'b0;
      s_bvalid <= 1'b0; s_bid <= '0; s_bresp <= OKAY;
    end else begin
      w_state <= w_next;
      if (s_awvalid && s_awready) begin
        w_id <= s_awid; w_addr <= s_awaddr; w_len <= s_awlen;
        w_size <= s_awsize; w_burst <= s_awburst;
        w_cnt <= '0;
        w_err <= bad_req(s_awsize, s_awburst);
      end
      if (w_fire) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 1'b1;
        w_err  <= w_err | beat_err;
        // Burst length comes from AWLEN; a misplaced WLAST only taints BRESP.
        if (w_last_beat) begin
          s_bvalid <= 1'b1;
          s_bid    <= w_id;
          s_bresp  <= (w_err | beat_err) ? SLVERR : OKAY;
        end
      end
      if (w_state == W_RESP && s_bready) s_bvalid <= 1'b0;
    end
  end

  // ---------------- memory ----------------
  logic [NB-1:0][7:0] rd_word;
  logic [IDXW-1:0]    rd_idx;

  // Lanes read the pre-edge contents, so a same-word write on the same edge
  // is not visible to the read (read-before-write).
  for (genvar i = 0; i < NB; i++) begin : g_lane
    axi_sram_lane #(.DEPTH(MEM_DEPTH), .IDXW(IDXW)) u_lane (
      .aclk  (aclk),
      .we    (aresetn && w_fire && s_wstrb[i]),
      .widx  (word_idx(w_addr)),
      .wbyte (s_wdata[8*i +: 8]),
      .ridx  (rd_idx),
      .rbyte (rd_word[i])
    );
  end

  // ---------------- read path ----------------
  r_state_t      r_state, r_next;
  logic [AW-1:0] r_addr, r_na;
  logic [LW-1:0] r_len, r_cnt;
  logic [SW-1:0] r_size;
  logic [BW-1:0] r_burst;
  logic          r_err;

  assign s_arready = (r_state == R_IDLE);
  assign r_na      = next_addr(r_addr, r_len, r_size, r_burst);
  // In IDLE the first beat is fetched from ARADDR; afterwards the next beat
  // is prefetched so it can load on the same edge as the current handshake.
  assign rd_idx    = (r_state == R_IDLE) ? word_idx(s_araddr) : word_idx(r_na);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_arvalid)            r_next = R_DATA;
      R_DATA:  if (s_rready && s_rlast)  r_next = R_IDLE;
      default:                           r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0; r_burst <= '0;
      r_err <= 1'b0;
      s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= '0;
      s_rid <= '0; s_rresp <= OKAY;
    end else begin
      r_state <= r_next;
      if (s_arvalid && s_arready) begin
        r_addr <= s_araddr; r_len <= s_arlen; r_size <= s_arsize;
        r_burst <= s_arburst; r_cnt <= '0;
        r_err    <= bad_req(s_arsize, s_arburst);
        s_rdata  <= rd_word;
        s_rvalid <= 1'b1;
        s_rid    <= s_arid;
        s_rlast  <= (s_arlen == '0);
        s_rresp  <= bad_req(s_arsize, s_arburst) ? SLVERR : OKAY;
      end else if (r_state == R_DATA && s_rready) begin
        if (s_rlast) begin
          s_rvalid <= 1'b0;
          s_rlast  <= 1'b0;
        end else begin
          r_addr  <= r_na;
          r_cnt   <= r_cnt + 1'b1;
          s_rdata <= rd_word;
          s_rlast <= ((r_cnt + 1'b1) == r_len);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single access, WRAP, R backpressure,
// protocol errors, B backpressure with a concurrent read, reset mid-burst.
module tb_axi_sram_slave;
  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [9:0]  s_awid = '0, s_wid = '0, s_bid, s_arid = '0, s_rid;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0, s_rdata;
  logic [7:0]  s_awlen = '0, s_arlen = '0;
  logic [2:0]  s_awsize = '0, s_arsize = '0;
  logic [1:0]  s_awburst = '0, s_arburst = '0, s_bresp, s_rresp;
  logic [3:0]  s_wstrb = '0;
  logic s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready;
  logic s_bvalid, s_bready = 0, s_arvalid = 0, s_arready;
  logic s_rlast, s_rvalid, s_rready = 0;

  int errors = 0, checks = 0;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic aw_send(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1;
    for (int n = 0; n < 50; n++) begin
      if (s_awready) begin step(); s_awvalid = 0; return; end
      step();
    end
    chk("aw_timeout", 0, 1); s_awvalid = 0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [9:0] id);
    s_wdata = data; s_wstrb = strb; s_wlast = last; s_wid = id; s_wvalid = 1;
    for (int n = 0; n < 50; n++) begin
      if (s_wready) begin step(); s_wvalid = 0; return; end
      step();
    end
    chk("w_timeout", 0, 1); s_wvalid = 0;
  endtask

  task automatic b_wait(input string tag, input logic [9:0] id, input logic [1:0] resp);
    s_bready = 1;
    for (int n = 0; n < 50; n++) begin
      if (s_bvalid) begin
        chk({tag, "_bid"}, s_bid, id);
        chk({tag, "_bresp"}, s_bresp, resp);
        step(); s_bready = 0; return;
      end
      step();
    end
    chk({tag, "_b_timeout"}, 0, 1); s_bready = 0;
  endtask

  task automatic ar_send(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1;
    for (int n = 0; n < 50; n++) begin
      if (s_arready) begin step(); s_arvalid = 0; return; end
      step();
    end
    chk("ar_timeout", 0, 1); s_arvalid = 0;
  endtask

  task automatic r_beat(input string tag, input logic [9:0] id, input logic [31:0] data,
                        input logic last, input logic [1:0] resp, input logic cmp_data);
    s_rready = 1;
    for (int n = 0; n < 50; n++) begin
      if (s_rvalid) begin
        chk({tag, "_rid"}, s_rid, id);
        if (cmp_data) chk({tag, "_rdata"}, s_rdata, data);
        chk({tag, "_rlast"}, s_rlast, last);
        chk({tag, "_rresp"}, s_rresp, resp);
        step(); s_rready = 0; return;
      end
      step();
    end
    chk({tag, "_r_timeout"}, 0, 1); s_rready = 0;
  endtask

  initial begin
    logic [31:0] exp4 [4];
    int beat;

    // reset state
    repeat (3) step();
    chk("rst_awready", s_awready, 1);
    chk("rst_arready", s_arready, 1);
    chk("rst_wready", s_wready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rlast", s_rlast, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_bid", s_bid, 0);
    aresetn = 1; step();

    // single write / read
    aw_send(1, 32'h10, 0, 2, 2'b01);
    w_beat(32'hDEADBEEF, 4'hF, 1, 1);
    b_wait("single", 1, 2'b00);
    ar_send(1, 32'h10, 0, 2, 2'b01);
    r_beat("single", 1, 32'hDEADBEEF, 1, 2'b00, 1);

    // WRAP halfword burst 0x4 -> 0x6 -> 0x0 -> 0x2
    aw_send(2, 32'h4, 3, 1, 2'b10);
    w_beat(32'h0000A1A1, 4'b0011, 0, 2);
    w_beat(32'hB2B20000, 4'b1100, 0, 2);
    w_beat(32'h0000C3C3, 4'b0011, 0, 2);
    w_beat(32'hD4D40000, 4'b1100, 1, 2);
    b_wait("wrap", 2, 2'b00);
    ar_send(3, 32'h0, 1, 2, 2'b01);
    r_beat("wrap0", 3, 32'hD4D4C3C3, 0, 2'b00, 1);
    r_beat("wrap1", 3, 32'hB2B2A1A1, 1, 2'b00, 1);

    // R backpressure: rready toggles every cycle
    aw_send(4, 32'h100, 3, 2, 2'b01);
    for (int k = 0; k < 4; k++) begin
      exp4[k] = 32'h11111111 * (k + 1);
      w_beat(exp4[k], 4'hF, k == 3, 4);
    end
    b_wait("tog_wr", 4, 2'b00);
    ar_send(5, 32'h100, 3, 2, 2'b01);
    beat = 0;
    for (int n = 0; n < 40 && beat < 4; n++) begin
      s_rready = (n % 2 == 1);
      chk("tog_rvalid", s_rvalid, 1);
      chk("tog_rdata", s_rdata, exp4[beat]);
      chk("tog_rlast", s_rlast, beat == 3);
      chk("tog_arready", s_arready, 0);
      if (s_rready) beat++;
      step();
    end
    s_rready = 0;
    chk("tog_beats", beat, 4);
    chk("tog_rvalid_end", s_rvalid, 0);
    chk("tog_arready_end", s_arready, 1);

    // early wlast: all four beats still taken, SLVERR
    aw_send(6, 32'h20, 3, 2, 2'b01);
    for (int k = 0; k < 4; k++) w_beat(32'hC0DE0000 + k, 4'hF, k == 1, 6);
    b_wait("wlast_err", 6, 2'b10);
    ar_send(6, 32'h2C, 0, 2, 2'b01);
    r_beat("wlast_beat4", 6, 32'hC0DE0003, 1, 2'b00, 1);

    // reserved burst code
    aw_send(7, 32'h30, 0, 2, 2'b11);
    w_beat(32'h0, 4'hF, 1, 7);
    b_wait("rsvd_burst", 7, 2'b10);

    // oversize read: SLVERR on every beat
    ar_send(8, 32'h10, 1, 3, 2'b01);
    r_beat("oversize0", 8, 32'h0, 0, 2'b10, 0);
    r_beat("oversize1", 8, 32'h0, 1, 2'b10, 0);

    // B backpressure with a concurrent read
    aw_send(5, 32'h40, 0, 2, 2'b01);
    w_beat(32'h55AA55AA, 4'hF, 1, 5);
    for (int n = 0; n < 5; n++) begin
      chk("bp_bvalid", s_bvalid, 1);
      chk("bp_bid", s_bid, 5);
      chk("bp_awready", s_awready, 0);
      if (n == 0) begin
        s_arid = 9; s_araddr = 32'h10; s_arlen = 0; s_arsize = 2; s_arburst = 2'b01;
        s_arvalid = 1;
        chk("bp_arready", s_arready, 1);
      end else if (n == 1) begin
        s_arvalid = 0;
        chk("bp_rvalid", s_rvalid, 1);
        chk("bp_rdata", s_rdata, 32'hDEADBEEF);
        chk("bp_rid", s_rid, 9);
        chk("bp_rlast", s_rlast, 1);
        s_rready = 1;
      end else if (n == 2) begin
        s_rready = 0;
        chk("bp_rvalid_done", s_rvalid, 0);
      end
      step();
    end
    s_bready = 1; step(); s_bready = 0;
    chk("bp_bvalid_rel", s_bvalid, 0);
    chk("bp_awready_rel", s_awready, 1);

    // reset after 2 of 4 W beats
    aw_send(6, 32'h60, 3, 2, 2'b01);
    w_beat(32'h66660001, 4'hF, 0, 6);
    w_beat(32'h66660002, 4'hF, 0, 6);
    aresetn = 0; step();
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_wready", s_wready, 0);
    chk("mid_rst_awready", s_awready, 1);
    step(); aresetn = 1; step();
    chk("post_rst_bvalid", s_bvalid, 0);
    chk("post_rst_wready", s_wready, 0);
    chk("post_rst_awready", s_awready, 1);
    ar_send(1, 32'h60, 1, 2, 2'b01);
    r_beat("partial0", 1, 32'h66660001, 0, 2'b00, 1);
    r_beat("partial1", 1, 32'h66660002, 1, 2'b00, 1);
    aw_send(3, 32'h70, 0, 2, 2'b01);
    w_beat(32'h12345678, 4'hF, 1, 3);
    b_wait("post_rst_wr", 3, 2'b00);
    ar_send(3, 32'h70, 0, 2, 2'b01);
    r_beat("post_rst_rd", 3, 32'h12345678, 1, 2'b00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
